// File: rtl/scan_code_pkg.sv
// Shared types and PS/2 scan-code constants for the keypad decoder.
package scan_code_pkg;

   typedef enum logic [1:0] {
      KC_DIGIT = 2'd0,
      KC_ENTER = 2'd1,
      KC_BKSP  = 2'd2,
      KC_ESC   = 2'd3
   } key_class_e;

   typedef struct packed {
      key_class_e cls;
      logic [3:0] num;
   } key_entry_t;

   typedef struct packed {
      logic       known;
      key_entry_t entry;
   } decode_t;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   localparam logic [7:0] SC_TOP_0 = 8'h45;
   localparam logic [7:0] SC_TOP_1 = 8'h16;
   localparam logic [7:0] SC_TOP_2 = 8'h1E;
   localparam logic [7:0] SC_TOP_3 = 8'h26;
   localparam logic [7:0] SC_TOP_4 = 8'h25;
   localparam logic [7:0] SC_TOP_5 = 8'h2E;
   localparam logic [7:0] SC_TOP_6 = 8'h36;
   localparam logic [7:0] SC_TOP_7 = 8'h3D;
   localparam logic [7:0] SC_TOP_8 = 8'h3E;
   localparam logic [7:0] SC_TOP_9 = 8'h46;

   localparam logic [7:0] SC_PAD_0 = 8'h70;
   localparam logic [7:0] SC_PAD_1 = 8'h69;
   localparam logic [7:0] SC_PAD_2 = 8'h72;
   localparam logic [7:0] SC_PAD_3 = 8'h7A;
   localparam logic [7:0] SC_PAD_4 = 8'h6B;
   localparam logic [7:0] SC_PAD_5 = 8'h73;
   localparam logic [7:0] SC_PAD_6 = 8'h74;
   localparam logic [7:0] SC_PAD_7 = 8'h6C;
   localparam logic [7:0] SC_PAD_8 = 8'h75;
   localparam logic [7:0] SC_PAD_9 = 8'h7D;

   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

endpackage

// File: rtl/scan_code_fifo_if.sv
// Receiver-side inputs and decoded-key FIFO outputs of scan_code_fifo.
interface scan_code_fifo_if
   import scan_code_pkg::*;
#(
   parameter int unsigned DEPTH = 4
);
   logic [15:0]           code;
   logic                  status;
   logic                  key_ready;
   logic                  clr_overflow;
   logic                  key_valid;
   key_class_e            key_class;
   logic [3:0]            key_num;
   logic [$clog2(DEPTH):0] count;
   logic                  hit;
   logic                  unknown;
   logic                  overflow;

   modport slave (
      input  code, status, key_ready, clr_overflow,
      output key_valid, key_class, key_num, count, hit, unknown, overflow
   );

   modport master (
      output code, status, key_ready, clr_overflow,
      input  key_valid, key_class, key_num, count, hit, unknown, overflow
   );
endinterface

// File: rtl/rise_detect.sv
// Registers a level and flags its low-to-high transition combinationally.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);
   logic r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_level <= 1'b0;
      else        r_level <= i_level;
   end

   assign o_rise = i_level & ~r_level;
endmodule

// File: rtl/scan_code_fifo.sv
// PS/2 key decoder: classifies scan codes on status edges and queues them in a FIFO.
module scan_code_fifo
   import scan_code_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAKE_MODE = 0,
   parameter int unsigned KEYPAD_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   scan_code_fifo_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   function automatic decode_t decode(logic [7:0] b, logic keypad);
      decode_t d;
      d.known     = 1'b1;
      d.entry.cls = KC_DIGIT;
      d.entry.num = 4'd0;
      case (b)
         SC_TOP_0: d.entry.num = 4'd0;
         SC_TOP_1: d.entry.num = 4'd1;
         SC_TOP_2: d.entry.num = 4'd2;
         SC_TOP_3: d.entry.num = 4'd3;
         SC_TOP_4: d.entry.num = 4'd4;
         SC_TOP_5: d.entry.num = 4'd5;
         SC_TOP_6: d.entry.num = 4'd6;
         SC_TOP_7: d.entry.num = 4'd7;
         SC_TOP_8: d.entry.num = 4'd8;
         SC_TOP_9: d.entry.num = 4'd9;
         SC_PAD_0: begin d.entry.num = 4'd0; d.known = keypad; end
         SC_PAD_1: begin d.entry.num = 4'd1; d.known = keypad; end
         SC_PAD_2: begin d.entry.num = 4'd2; d.known = keypad; end
         SC_PAD_3: begin d.entry.num = 4'd3; d.known = keypad; end
         SC_PAD_4: begin d.entry.num = 4'd4; d.known = keypad; end
         SC_PAD_5: begin d.entry.num = 4'd5; d.known = keypad; end
         SC_PAD_6: begin d.entry.num = 4'd6; d.known = keypad; end
         SC_PAD_7: begin d.entry.num = 4'd7; d.known = keypad; end
         SC_PAD_8: begin d.entry.num = 4'd8; d.known = keypad; end
         SC_PAD_9: begin d.entry.num = 4'd9; d.known = keypad; end
         SC_ENTER: d.entry.cls = KC_ENTER;
         SC_BKSP:  d.entry.cls = KC_BKSP;
         SC_ESC:   d.entry.cls = KC_ESC;
         default:  d.known = 1'b0;
      endcase
      return d;
   endfunction

   logic             w_rise;
   logic             w_qual;
   logic             w_edge;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   decode_t          w_dec;

   key_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_hit;
   logic             r_unknown;
   logic             r_overflow;

   rise_detect u_rise_detect (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (bus.status),
      .o_rise  (w_rise)
   );

   assign w_qual = (MAKE_MODE != 0) ? (bus.code[15:8] != BREAK_PREFIX)
                                    : (bus.code[15:8] == BREAK_PREFIX);
   assign w_dec  = decode(bus.code[7:0], KEYPAD_EN != 0);
   assign w_edge = w_rise & w_qual;
   assign w_full = (r_count == CNT_W'(DEPTH));
   assign w_pop  = (r_count != '0) & bus.key_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = w_edge & w_dec.known & (~w_full | w_pop);
   assign w_drop = w_edge & w_dec.known & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wptr] <= w_dec.entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_hit      <= 1'b0;
         r_unknown  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_hit     <= w_edge & w_dec.known;
         r_unknown <= w_edge & ~w_dec.known;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop)                r_overflow <= 1'b1;
         else if (bus.clr_overflow) r_overflow <= 1'b0;
      end
   end

   assign bus.key_valid = (r_count != '0);
   assign bus.key_class = r_mem[r_rptr].cls;
   assign bus.key_num   = r_mem[r_rptr].num;
   assign bus.count     = r_count;
   assign bus.hit       = r_hit;
   assign bus.unknown   = r_unknown;
   assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_scan_code_fifo.sv
// Bench for scan_code_fifo: three parameter variants share one stimulus stream.
module tb_scan_code_fifo;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] code = 16'h0000;
   logic        status = 1'b0;
   logic        key_ready = 1'b0;
   logic        clr_overflow = 1'b0;
   logic        done = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   scan_code_fifo_if #(.DEPTH(DEPTH)) if0 ();
   scan_code_fifo_if #(.DEPTH(DEPTH)) if1 ();
   scan_code_fifo_if #(.DEPTH(DEPTH)) if2 ();

   assign if0.code = code;  assign if0.status = status;
   assign if0.key_ready = key_ready;  assign if0.clr_overflow = clr_overflow;
   assign if1.code = code;  assign if1.status = status;
   assign if1.key_ready = key_ready;  assign if1.clr_overflow = clr_overflow;
   assign if2.code = code;  assign if2.status = status;
   assign if2.key_ready = key_ready;  assign if2.clr_overflow = clr_overflow;

   scan_code_fifo #(.DEPTH(DEPTH), .MAKE_MODE(0), .KEYPAD_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   scan_code_fifo #(.DEPTH(DEPTH), .MAKE_MODE(0), .KEYPAD_EN(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));
   scan_code_fifo #(.DEPTH(DEPTH), .MAKE_MODE(1), .KEYPAD_EN(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2));

   // Model: per variant, a queue of entries encoded as class*16 + digit.
   int m_mode [3] = '{0, 0, 1};
   int m_pad  [3] = '{1, 0, 1};
   int mq     [3][$];
   bit m_prev [3];
   bit m_hit  [3];
   bit m_unk  [3];
   bit m_ovf  [3];
   int md;
   bit mrise, mqual, mpop, mfull;

   function automatic int model_decode(logic [7:0] b, int pad);
      logic [7:0] top [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      logic [7:0] npd [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                               8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
      for (int k = 0; k < 10; k++) begin
         if (b == top[k]) return k;
         if (pad != 0 && b == npd[k]) return k;
      end
      if (b == 8'h5A) return 16;
      if (b == 8'h66) return 32;
      if (b == 8'h76) return 48;
      return -1;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
               mq[i].delete();
               m_prev[i] = 1'b0; m_hit[i] = 1'b0; m_unk[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
               mrise = status && !m_prev[i];
               m_prev[i] = status;
               mqual = (m_mode[i] != 0) ? (code[15:8] != 8'hF0) : (code[15:8] == 8'hF0);
               md = model_decode(code[7:0], m_pad[i]);
               mfull = (mq[i].size() == DEPTH);
               mpop = (mq[i].size() != 0) && key_ready;
               m_hit[i] = mrise && mqual && md >= 0;
               m_unk[i] = mrise && mqual && md < 0;
               if (mpop) void'(mq[i].pop_front());
               if (m_hit[i]) begin
                  if (!mfull || mpop) mq[i].push_back(md);
                  else m_ovf[i] = 1'b1;
               end
               if (!(m_hit[i] && mfull && !mpop) && clr_overflow) m_ovf[i] = 1'b0;
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_inst(int i, logic v, logic [1:0] c, logic [3:0] n,
                             logic [2:0] cnt, logic h, logic u, logic o);
      chk($sformatf("i%0d valid", i), 32'(v), 32'(mq[i].size() != 0));
      chk($sformatf("i%0d count", i), 32'(cnt), 32'(mq[i].size()));
      chk($sformatf("i%0d hit", i), 32'(h), 32'(m_hit[i]));
      chk($sformatf("i%0d unknown", i), 32'(u), 32'(m_unk[i]));
      chk($sformatf("i%0d overflow", i), 32'(o), 32'(m_ovf[i]));
      if (mq[i].size() != 0) begin
         chk($sformatf("i%0d class", i), 32'(c), 32'(mq[i][0] / 16));
         chk($sformatf("i%0d num", i), 32'(n), 32'(mq[i][0] % 16));
      end
   endtask

   initial begin
      while (!done) begin
         @(negedge clk);
         if (!done) begin
            check_inst(0, if0.key_valid, if0.key_class, if0.key_num, if0.count,
                       if0.hit, if0.unknown, if0.overflow);
            check_inst(1, if1.key_valid, if1.key_class, if1.key_num, if1.count,
                       if1.hit, if1.unknown, if1.overflow);
            check_inst(2, if2.key_valid, if2.key_class, if2.key_num, if2.count,
                       if2.hit, if2.unknown, if2.overflow);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // Guarantees one low sample of status, then holds it high for one sample.
   task automatic edge_in(logic [15:0] c);
      @(posedge clk); #2;
      code = c; status = 1'b1;
      @(posedge clk); #2;
      status = 1'b0;
   endtask

   task automatic pop1();
      key_ready = 1'b1;
      @(posedge clk); #2;
      key_ready = 1'b0;
   endtask

   task automatic pop_expect(string nm, int cls, int num);
      chk({nm, " class"}, 32'(if0.key_class), 32'(cls));
      chk({nm, " num"}, 32'(if0.key_num), 32'(num));
      pop1();
   endtask

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(1);
      chk("reset valid", 32'(if0.key_valid), 32'd0);
      chk("reset count", 32'(if0.count), 32'd0);
      chk("reset class", 32'(if0.key_class), 32'd0);
      chk("reset num", 32'(if0.key_num), 32'd0);
      chk("reset overflow", 32'(if0.overflow), 32'd0);

      edge_in(16'hF016);
      chk("F016 hit", 32'(if0.hit), 32'd1);
      chk("F016 valid", 32'(if0.key_valid), 32'd1);
      chk("F016 class", 32'(if0.key_class), 32'd0);
      chk("F016 num", 32'(if0.key_num), 32'd1);
      chk("F016 count", 32'(if0.count), 32'd1);
      idle(1);
      chk("hit one cycle", 32'(if0.hit), 32'd0);
      pop1();
      chk("after pop count", 32'(if0.count), 32'd0);

      edge_in(16'hF05A);
      edge_in(16'hF066);
      edge_in(16'hF076);
      edge_in(16'hF045);
      chk("peak count", 32'(if0.count), 32'd4);
      pop_expect("pop ENTER", 1, 0);
      pop_expect("pop BKSP", 2, 0);
      pop_expect("pop ESC", 3, 0);
      pop_expect("pop DIGIT0", 0, 0);

      repeat (5) edge_in(16'hF01E);
      chk("ovf count", 32'(if0.count), 32'd4);
      chk("ovf flag", 32'(if0.overflow), 32'd1);
      chk("ovf hit on drop", 32'(if0.hit), 32'd1);
      clr_overflow = 1'b1;
      idle(1);
      clr_overflow = 1'b0;
      chk("ovf cleared", 32'(if0.overflow), 32'd0);
      for (int k = 0; k < 4; k++) pop_expect($sformatf("drain%0d", k), 0, 2);
      chk("drained", 32'(if0.count), 32'd0);

      edge_in(16'hF070);
      chk("pad0 hit", 32'(if0.hit), 32'd1);
      chk("pad0 nopad unknown", 32'(if1.unknown), 32'd1);
      chk("pad0 nopad count", 32'(if1.count), 32'd0);
      idle(1);
      chk("pad0 num", 32'(if0.key_num), 32'd0);
      edge_in(16'hF0AA);
      chk("AA unknown", 32'(if0.unknown), 32'd1);
      chk("AA no hit", 32'(if0.hit), 32'd0);
      pop1();

      edge_in(16'h0016);
      chk("make 0016 hit", 32'(if2.hit), 32'd1);
      chk("make 0016 num", 32'(if2.key_num), 32'd1);
      chk("break 0016 ignored", 32'(if0.hit | if0.unknown), 32'd0);
      edge_in(16'hF016);
      chk("make F016 no hit", 32'(if2.hit), 32'd0);
      chk("make F016 no unknown", 32'(if2.unknown), 32'd0);
      pop1();
      idle(1);

      repeat (4) edge_in(16'hF01E);
      @(posedge clk); #2;
      code = 16'hF046; status = 1'b1; key_ready = 1'b1;
      @(posedge clk); #2;
      status = 1'b0; key_ready = 1'b0;
      chk("push+pop count", 32'(if0.count), 32'd4);
      chk("push+pop no ovf", 32'(if0.overflow), 32'd0);
      repeat (3) pop1();
      chk("tail 9 class", 32'(if0.key_class), 32'd0);
      chk("tail 9 num", 32'(if0.key_num), 32'd9);

      edge_in(16'hF05A);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset valid", 32'(if0.key_valid), 32'd0);
      chk("midreset count", 32'(if0.count), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(3);

      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scan_code_fifo.md
Name: scan_code_fifo

Overview:
- Parametrised PS/2 key decoder with a buffered output.
- Samples a 16-bit scan-code window (previous byte, current byte) on each rising edge of the receiver's status flag.
- Classifies the key as a digit (top row or numpad) or a control key (Enter, Backspace, Esc).
- Queues decoded keys in a small FIFO with a valid/ready handshake. Sits between the PS/2 receiver and the numeric-entry/display logic.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- MAKE_MODE, 0: 0 = decode break codes (code[15:8] == 8'hF0); 1 = decode make codes (code[15:8] != 8'hF0).
- KEYPAD_EN, 1: 1 = numpad digit codes also decode as digits; 0 = numpad codes are unknown.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- code  in  16  scan-code window {prev_byte, cur_byte}
- status  in  1  receiver "new code" level
- key_ready  in  1  consumer accepts head entry
- clr_overflow  in  1  clears the overflow flag
- key_valid  out  1  FIFO non-empty
- key_class  out  2  head class: 0 DIGIT, 1 ENTER, 2 BKSP, 3 ESC
- key_num  out  4  head digit 0-9; 0 for non-digit classes
- count  out  $clog2(DEPTH)+1  current occupancy
- hit  out  1  one-cycle pulse: a known key was decoded this cycle
- unknown  out  1  one-cycle pulse: an edge arrived but the code did not decode
- overflow  out  1  sticky: a decoded key was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: FIFO empty, key_valid=0, count=0, key_class=0, key_num=0, hit=0, unknown=0, overflow=0.
- Edge detect: status_q is a register of status. rise = status & ~status_q (combinational).
- Qualifier: in MAKE_MODE=0, decode only if code[15:8]==F0. In MAKE_MODE=1, decode only if code[15:8]!=F0. An unqualified edge is silently ignored: no hit, no unknown.
- Digit map on code[7:0]:
  - Top row: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - Numpad (KEYPAD_EN=1 only): 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9.
- Control map on code[7:0]: 5A ENTER, 66 BKSP, 76 ESC.
- Decision is made on the clk edge where rise=1 and the qualifier is true:
  - Known code: push {class, num}; hit=1 on the next cycle for exactly one cycle.
  - Otherwise: unknown=1 on the next cycle for one cycle.
- Latency: edge sampled at cycle N → key_valid/head data visible from cycle N+1 (if the FIFO was empty).
- The E0 extended prefix is not distinguished: E0 5A decodes as ENTER.
- MAKE_MODE=1 typematic repeats: each new status edge pushes again.
- status held high: exactly one push per rising edge. status low→high on consecutive cycles is not possible; min 1 low cycle between edges.
- Pop: when key_valid & key_ready at a clk edge, the head is removed.
- key_valid = (count != 0). key_class/key_num reflect the head entry and are stable while key_valid=1 and key_ready=0.
- While empty, key_class/key_num are don't-care for checking; the implementation drives the stale RAM value.
- Push while full:
  - With a simultaneous pop: accepted, count unchanged.
  - Without a pop: entry dropped, overflow set to 1 on the next cycle, hit still pulses.
- Pop while empty: ignored, count stays 0.
- Push while empty with key_ready=1: no bypass; the entry appears at N+1 and pops at the earliest on the N+1 edge.
- overflow clears when clr_overflow=1 at a clk edge. A simultaneous set and clear resolves as set.
- Pointers: $clog2(DEPTH)-bit read/write pointers wrap naturally. count is tracked separately, range 0..DEPTH.
- Reset mid-operation flushes the FIFO and status_q immediately. The first edge after reset is detected only when status is sampled low then high.

Decomposition:
- Package scan_code_pkg:
  - Class enum constants KC_DIGIT/KC_ENTER/KC_BKSP/KC_ESC.
  - BREAK_PREFIX=8'hF0.
  - All scan-code byte constants (top-row, numpad, control).
- Sub-module: rise_detect (status → rise, asynchronous reset), reusable elsewhere.
- Decode is a combinational function/case in the top. The FIFO is inline: register array plus pointers.

Test Plan:
- MAKE_MODE=0: code=F016, status 0→1 → hit pulse, next cycle key_valid=1, class=0, num=1, count=1. key_ready=1 one cycle → count=0.
- code=F05A, F066, F076, F045 with key_ready=0 → pops in order give ENTER, BKSP, ESC, DIGIT 0; count peaks at 4.
- DEPTH=4: five edges with F01E, key_ready=0 → count=4, overflow=1. The fifth is dropped; reads give four entries of num=2. clr_overflow → overflow=0.
- code=F070 with KEYPAD_EN=1 → DIGIT 0. Same code with KEYPAD_EN=0 → unknown pulse, no push. code=F0AA → unknown pulse.
- MAKE_MODE=1: code=0016 edge → DIGIT 1 pushed. code=F016 edge → no hit, no unknown.
- Full FIFO with simultaneous push (F046) and pop → count stays 4, the 9 lands at the tail. Assert rst_n mid-stream → key_valid=0, count=0 immediately.
